mux_rr_arb: RTL

- Parametrised N-channel, W-bit multiplexer; successor to the gate-level 2:1 mux.
- Channel selection is by round-robin arbitration, not by an external select line.
- Each input uses a valid/ready handshake. The output is a one-entry register that also uses valid/ready.
- Sits between multiple producers and a single shared consumer, such as a shared bus or a debug/trace port.

---
 rtl/mux_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/mux_rr_arb.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin multiplexer family: channel limits,
// index-width helper and the channel-index type.
package mux_pkg;

    localparam int MUX_MAX_CH = 16;

    // Width of a channel index; never less than one bit so N=1 still has a port.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef logic [$clog2(MUX_MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with
// wrap modulo N. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             found
);

    int idx;

    // Scan from the farthest candidate back toward ptr so the nearest one wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                win   = SEL_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel round-robin multiplexer with valid/ready inputs and a one-entry
// registered output. Per-channel grant counters exist with MUX_RR_ARB_GRANT_CNT_EN.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = idx_width(N_CH),
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*W-1:0]     in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
`ifdef MUX_RR_ARB_GRANT_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);

    generate
        if (N_CH < 1 || N_CH > MUX_MAX_CH || W < 1 || CNT_W < 1) begin : g_bad_cfg
            $error("mux_rr_arb: unsupported parameter set");
        end
    endgenerate

    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             load;
    logic             out_valid_reg;
    logic [W-1:0]     out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;

    rr_pick #(
        .N     (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .win   (win),
        .found (found)
    );

    // rst gating keeps producers from seeing a grant that the reset will discard.
    assign load = found && (!out_valid_reg || out_ready) && !rst;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[win] = 1'b1;
        end
    end

    // Explicit wrap so a non-power-of-2 channel count never reaches N_CH.
    assign ptr_next = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data[int'(win)*W +: W];
            out_sel_reg   <= win;
            ptr_reg       <= ptr_next;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

`ifdef MUX_RR_ARB_GRANT_CNT_EN
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating: a stuck count is more useful to a debugger than a wrapped one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (load && win == SEL_W'(gi) && cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule
